subneg_core_param: RTL
======================

// Module: subneg_core_param
// PURPOSE
//   Parametrised SUBNEG one-instruction CPU core driving an external latched-address memory.
//   Executes mem[B] <= mem[B] - mem[A]; branches to C when the result is negative, else PC <= PC+3.
//   Shares one DATA_W-bit bidirectional bus for address and data (LE latches address, MOE/MWE strobe).
//   Adds run/halt control and a memory-mapped output register; sits between the TT pad wrapper and
//   the external SRAM/latch.
// PARAMETERS
//   DATA_W    8      data and address width in bits; all PC/operand arithmetic wraps modulo 2**DATA_W
//   OUT_ADDR  8'hFF  write address redirected to out_data instead of memory
//   START_PC  0      PC value loaded on reset
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   reset      in   1       synchronous, active-high reset
//   run        in   1       start/continue execution; sampled only at instruction boundaries
//   bus_in     in   DATA_W  data from memory, sampled in RD_CAP
//   bus_out    out  DATA_W  address (ADDR phase) or write data (write phases)
//   bus_oe     out  DATA_W  all-ones while core drives bus, all-zeros otherwise
//   le         out  1       address latch enable, high only in ADDR
//   moe        out  1       memory output enable, high in RD_OE and RD_CAP
//   mwe        out  1       memory write enable, high only in WR_DATA
//   out_data   out  DATA_W  last value written to OUT_ADDR
//   out_valid  out  1       one-cycle pulse when out_data is updated
//   halted     out  1       high once a halt is taken; cleared only by reset
//   pc         out  DATA_W  current program counter
// BEHAVIOUR
//   Reset: state IDLE, pc=START_PC, le=moe=mwe=0, bus_oe=0, bus_out=0, out_data=0, out_valid=0,
//     halted=0. Reset takes effect at any cycle, including mid-read/write; mwe drops on that edge.
//   States: IDLE, ADDR, RD_OE, RD_CAP, WR_DATA, WR_DONE, EXEC, HALT.
//   Step counter: FA, FB, FC (fetch at pc, pc+1, pc+2, wrapping), RA (mem[A]), RB (mem[B]), WB.
//   Read access, 3 cycles:
//     ADDR: bus_out=addr, bus_oe=1s, le=1.
//     RD_OE: le=0, bus_oe=0, moe=1.
//     RD_CAP: moe=1, capture bus_in into the step's register.
//   Write access, 3 cycles:
//     ADDR.
//     WR_DATA: le=0, bus_out=result, bus_oe=1s, mwe=1.
//     WR_DONE: mwe=0, bus_oe still 1s, data held.
//   IDLE -> ADDR(FA) when run=1. After RB's RD_CAP -> EXEC.
//   EXEC (1 cycle):
//     diff = sext(valB) - sext(valA) at DATA_W+1 bits; result = diff[DATA_W-1:0].
//     neg = diff[DATA_W] (true signed sign, no overflow aliasing).
//     pc <= neg ? C : pc+3 (wraps).
//     If B==OUT_ADDR: out_data<=result and out_valid=1 this cycle, no bus write.
//     Otherwise: write result to B.
//   Halt: neg && C==pc (self-branch) -> after the write/output completes, go to HALT.
//     HALT: halted=1, bus quiet (all strobes 0, bus_oe=0) until reset.
//   End of instruction (no halt): run=1 -> ADDR(FA); run=0 -> IDLE.
//     A run drop mid-instruction never aborts the instruction.
//   Latency (ADDR(FA) to next ADDR(FA)): 19 cycles normal, 16 cycles when B==OUT_ADDR.
//   A read of OUT_ADDR is an ordinary bus read.
//   le, moe and mwe are never high together; bus_oe=0 whenever moe=1.
// TESTING
//   1. Reset, run=0 for 20 cycles -> le=moe=mwe=0, bus_oe=0, pc=0, halted=0.
//   2. mem[0..2]={10,11,20}, mem[10]=3, mem[11]=5, run=1 -> le addresses 0,1,2,10,11,11;
//      mwe with bus_out=2; pc=3 after 19 cycles.
//   3. mem[10]=5, mem[11]=3 -> mem[11]=8'hFE, pc=20.
//      mem[10]=8'h81, mem[11]=8'h7F -> mem[11]=8'hFE, no branch (signed), pc=3.
//   4. B=8'hFF, mem[A]=1, mem[FF]=9 -> out_data=8, single out_valid pulse, no mwe, next fetch 16 cycles later.
//   5. At pc=6: A,B give a negative result with C=6 -> write completes, halted=1, no further le;
//      reset clears it.
//   6. START_PC=8'hFE -> fetch addresses FE,FF,00.
//      reset asserted during WR_DATA -> mwe=0 next edge, state IDLE.

Source files
------------

// File: rtl/subneg_core_param.sv
// SUBNEG one-instruction CPU core.
// Executes mem[B] <= mem[B] - mem[A] and branches to C on a negative result,
// otherwise advances pc by 3. Address and data share one bus: an address phase
// pulses le so the external latch captures the address, then moe (read) or
// mwe (write) strobes the data. A write to OUT_ADDR is redirected to out_data.
module subneg_core_param #(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  OUT_ADDR = 8'hFF,
    parameter logic [DATA_W-1:0]  START_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] bus_oe,
    output logic              le,
    output logic              moe,
    output logic              mwe,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [DATA_W-1:0] pc
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_RD_OE, ST_RD_CAP, ST_WR_DATA, ST_WR_DONE, ST_EXEC, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        STEP_FA, STEP_FB, STEP_FC, STEP_RA, STEP_RB, STEP_WB
    } step_t;

    localparam logic [DATA_W-1:0] PC_INC1 = DATA_W'(1);
    localparam logic [DATA_W-1:0] PC_INC2 = DATA_W'(2);
    localparam logic [DATA_W-1:0] PC_INC3 = DATA_W'(3);

    state_t            state_q, state_d;
    step_t             step_q, step_d;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] a_q, b_q, c_q;        // operand addresses
    logic [DATA_W-1:0] va_q, vb_q;           // operand values
    logic [DATA_W-1:0] result_q;
    logic              halt_q;               // halt pending after the write finishes
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] result;
    logic              neg;
    logic              is_out;
    logic              halt_now;
    logic [DATA_W-1:0] access_addr;

    // Subtract at one extra bit so the sign is the true signed sign, immune to overflow.
    always_comb begin
        diff     = {vb_q[DATA_W-1], vb_q} - {va_q[DATA_W-1], va_q};
        result   = diff[DATA_W-1:0];
        neg      = diff[DATA_W];
        is_out   = (b_q == OUT_ADDR);
        halt_now = neg && (c_q == pc_q);
    end

    // Address presented in the ADDR phase for the current access step.
    always_comb begin
        access_addr = pc_q;
        case (step_q)
            STEP_FA: access_addr = pc_q;
            STEP_FB: access_addr = pc_q + PC_INC1;
            STEP_FC: access_addr = pc_q + PC_INC2;
            STEP_RA: access_addr = a_q;
            default: access_addr = b_q;
        endcase
    end

    // State and step registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_FA;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic; run is only looked at on instruction boundaries.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_ADDR;
                    step_d  = STEP_FA;
                end
            end
            ST_ADDR:   state_d = (step_q == STEP_WB) ? ST_WR_DATA : ST_RD_OE;
            ST_RD_OE:  state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                if (step_q == STEP_RB) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_ADDR;
                    case (step_q)
                        STEP_FA: step_d = STEP_FB;
                        STEP_FB: step_d = STEP_FC;
                        STEP_FC: step_d = STEP_RA;
                        default: step_d = STEP_RB;
                    endcase
                end
            end
            ST_EXEC: begin
                if (!is_out) begin
                    state_d = ST_ADDR;
                    step_d  = STEP_WB;
                end else if (halt_now) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_ADDR;
                    step_d  = STEP_FA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: state_d = ST_WR_DONE;
            ST_WR_DONE: begin
                if (halt_q) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_ADDR;
                    step_d  = STEP_FA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, execute, pc update and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= START_PC;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            result_q    <= '0;
            halt_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == ST_RD_CAP) begin
                case (step_q)
                    STEP_FA: a_q  <= bus_in;
                    STEP_FB: b_q  <= bus_in;
                    STEP_FC: c_q  <= bus_in;
                    STEP_RA: va_q <= bus_in;
                    default: vb_q <= bus_in;
                endcase
            end
            if (state_q == ST_EXEC) begin
                pc_q     <= neg ? c_q : pc_q + PC_INC3;
                result_q <= result;
                halt_q   <= halt_now;
                if (is_out) begin
                    out_data_q  <= result;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    // Bus strobes decoded from state; the core never drives the bus while memory does.
    always_comb begin
        bus_out = '0;
        bus_oe  = '0;
        le      = 1'b0;
        moe     = 1'b0;
        mwe     = 1'b0;
        case (state_q)
            ST_ADDR: begin
                bus_out = access_addr;
                bus_oe  = '1;
                le      = 1'b1;
            end
            ST_RD_OE, ST_RD_CAP: moe = 1'b1;
            ST_WR_DATA: begin
                bus_out = result_q;
                bus_oe  = '1;
                mwe     = 1'b1;
            end
            ST_WR_DONE: begin
                bus_out = result_q;
                bus_oe  = '1;
            end
            default: ;
        endcase
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign pc        = pc_q;

endmodule
